// File: rtl/issue_pkg.sv
// Shared issue-queue types: FU class encodings and the entry record.
package issue_pkg;

   localparam logic [1:0] FU_ALU = 2'd0;
   localparam logic [1:0] FU_MUL = 2'd1;
   localparam logic [1:0] FU_LS  = 2'd2;
   localparam logic [1:0] FU_BR  = 2'd3;

   localparam int unsigned IQ_PRF_WIDTH    = 6;
   localparam int unsigned IQ_OPCODE_WIDTH = 7;
   localparam int unsigned IQ_AGE_WIDTH    = 5;

   typedef struct packed {
      logic                       valid;
      logic [IQ_OPCODE_WIDTH-1:0] op;
      logic [1:0]                 fu;
      logic [IQ_PRF_WIDTH-1:0]    prd;
      logic                       prd_v;
      logic [IQ_PRF_WIDTH-1:0]    prs1;
      logic                       prs1_v;
      logic                       prs1_rdy;
      logic [IQ_PRF_WIDTH-1:0]    prs2;
      logic                       prs2_v;
      logic                       prs2_rdy;
      logic [IQ_AGE_WIDTH-1:0]    age;
   } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Oldest-ready picker for one issue port: maximum age wins, ties go to the lowest index.
module iq_select #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AGE_WIDTH = 5
) (
   input  logic [DEPTH-1:0]           req,
   input  logic [DEPTH*AGE_WIDTH-1:0] age,
   output logic                       gnt_v,
   output logic [$clog2(DEPTH)-1:0]   gnt_idx,
   output logic [DEPTH-1:0]           gnt_oh
);

   logic [AGE_WIDTH-1:0] best_age;

   always_comb begin
      gnt_v    = 1'b0;
      gnt_idx  = '0;
      best_age = '0;
      gnt_oh   = '0;
      // Strict compare keeps the earliest index on equal ages.
      for (int i = 0; i < DEPTH; i++) begin
         if (req[i] && (!gnt_v || (age[i*AGE_WIDTH +: AGE_WIDTH] > best_age))) begin
            gnt_v    = 1'b1;
            gnt_idx  = ($clog2(DEPTH))'(i);
            best_age = age[i*AGE_WIDTH +: AGE_WIDTH];
         end
      end
      if (gnt_v) gnt_oh[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered issue queue with tag wakeup and per-port oldest-ready select.
// Define IQ_SPEC_WAKEUP_EN to broadcast granted prd tags as wakeups for back-to-back issue.
module issue_queue
   import issue_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned NUM_ISSUE    = 4,
   parameter int unsigned NUM_WB       = 2,
   parameter int unsigned PRF_WIDTH    = IQ_PRF_WIDTH,
   parameter int unsigned OPCODE_WIDTH = IQ_OPCODE_WIDTH,
   parameter int unsigned AGE_WIDTH    = IQ_AGE_WIDTH,
   parameter logic [2*NUM_ISSUE-1:0] PORT_FU = {FU_LS, FU_MUL, FU_ALU, FU_ALU}
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              disp_valid,
   output logic                              disp_ready,
   input  logic [OPCODE_WIDTH-1:0]           disp_op,
   input  logic [1:0]                        disp_fu,
   input  logic [PRF_WIDTH-1:0]              disp_prd,
   input  logic                              disp_prd_v,
   input  logic [PRF_WIDTH-1:0]              disp_prs1,
   input  logic                              disp_prs1_v,
   input  logic                              disp_prs1_rdy,
   input  logic [PRF_WIDTH-1:0]              disp_prs2,
   input  logic                              disp_prs2_v,
   input  logic                              disp_prs2_rdy,
   input  logic [NUM_WB-1:0]                 wb_valid,
   input  logic [NUM_WB*PRF_WIDTH-1:0]       wb_prd,
   input  logic [NUM_ISSUE-1:0]              iss_ready,
   output logic [NUM_ISSUE-1:0]              iss_valid,
   output logic [NUM_ISSUE*OPCODE_WIDTH-1:0] iss_op,
   output logic [NUM_ISSUE*PRF_WIDTH-1:0]    iss_prd,
   output logic [NUM_ISSUE-1:0]              iss_prd_v,
   output logic [NUM_ISSUE*PRF_WIDTH-1:0]    iss_prs1,
   output logic [NUM_ISSUE*PRF_WIDTH-1:0]    iss_prs2,
   output logic [$clog2(DEPTH):0]            count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;
`ifdef IQ_SPEC_WAKEUP_EN
   localparam int unsigned NUM_WAKE = NUM_WB + NUM_ISSUE;
`else
   localparam int unsigned NUM_WAKE = NUM_WB;
`endif

   iq_entry_t ent_q [DEPTH];
   iq_entry_t ent_d [DEPTH];
   iq_entry_t new_ent;
   logic [CNT_W-1:0] count_q, count_d, num_gnt;
   logic [IDX_W-1:0] disp_slot, gnt_idx [NUM_ISSUE];
   logic slot_found, disp_fire;
   logic [DEPTH-1:0] req, fu_req [NUM_ISSUE], taken [NUM_ISSUE+1];
   logic [DEPTH*AGE_WIDTH-1:0] age_vec;
   logic [NUM_ISSUE-1:0] gnt_v;
   logic [NUM_WAKE-1:0] wake_v;
   logic [PRF_WIDTH-1:0] wake_tag [NUM_WAKE];

   assign disp_ready = rst_n && !flush && (count_q < CNT_W'(DEPTH));
   assign disp_fire  = disp_valid && disp_ready;
   assign count      = count_q;

   always_comb begin
      req     = '0;
      age_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         req[i] = ent_q[i].valid && (!ent_q[i].prs1_v || ent_q[i].prs1_rdy) &&
                  (!ent_q[i].prs2_v || ent_q[i].prs2_rdy);
         age_vec[i*AGE_WIDTH +: AGE_WIDTH] = ent_q[i].age;
      end
      for (int p = 0; p < NUM_ISSUE; p++) begin
         fu_req[p] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            fu_req[p][i] = req[i] && (ent_q[i].fu == PORT_FU[2*p +: 2]);
         end
      end
   end

   // Lower-numbered ports pick first; their grants are masked from later ports.
   assign taken[0] = '0;
   for (genvar p = 0; p < NUM_ISSUE; p++) begin : g_port
      logic [DEPTH-1:0] port_req, port_oh;
      assign port_req = fu_req[p] & ~taken[p] & {DEPTH{iss_ready[p] & ~flush}};
      iq_select #(
         .DEPTH     (DEPTH),
         .AGE_WIDTH (AGE_WIDTH)
      ) u_select (
         .req     (port_req),
         .age     (age_vec),
         .gnt_v   (gnt_v[p]),
         .gnt_idx (gnt_idx[p]),
         .gnt_oh  (port_oh)
      );
      assign taken[p+1] = taken[p] | port_oh;
   end

   always_comb begin
      for (int w = 0; w < NUM_WB; w++) begin
         wake_v[w]   = wb_valid[w];
         wake_tag[w] = wb_prd[w*PRF_WIDTH +: PRF_WIDTH];
      end
`ifdef IQ_SPEC_WAKEUP_EN
      for (int p = 0; p < NUM_ISSUE; p++) begin
         wake_v[NUM_WB+p]   = gnt_v[p] && ent_q[gnt_idx[p]].prd_v;
         wake_tag[NUM_WB+p] = ent_q[gnt_idx[p]].prd;
      end
`endif
   end

   always_comb begin
      disp_slot  = '0;
      slot_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!ent_q[i].valid && !slot_found) begin
            disp_slot  = IDX_W'(i);
            slot_found = 1'b1;
         end
      end
   end

   // Sources matching a same-cycle wakeup are written already ready.
   always_comb begin
      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.op       = disp_op;
      new_ent.fu       = disp_fu;
      new_ent.prd      = disp_prd;
      new_ent.prd_v    = disp_prd_v;
      new_ent.prs1     = disp_prs1;
      new_ent.prs1_v   = disp_prs1_v;
      new_ent.prs1_rdy = disp_prs1_rdy;
      new_ent.prs2     = disp_prs2;
      new_ent.prs2_v   = disp_prs2_v;
      new_ent.prs2_rdy = disp_prs2_rdy;
      for (int w = 0; w < NUM_WAKE; w++) begin
         if (wake_v[w] && (disp_prs1 == wake_tag[w])) new_ent.prs1_rdy = 1'b1;
         if (wake_v[w] && (disp_prs2 == wake_tag[w])) new_ent.prs2_rdy = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].valid && (ent_q[i].age != '1)) begin
            ent_d[i].age = ent_q[i].age + AGE_WIDTH'(1);
         end
         for (int w = 0; w < NUM_WAKE; w++) begin
            if (wake_v[w] && (ent_q[i].prs1 == wake_tag[w])) ent_d[i].prs1_rdy = 1'b1;
            if (wake_v[w] && (ent_q[i].prs2 == wake_tag[w])) ent_d[i].prs2_rdy = 1'b1;
         end
         if (taken[NUM_ISSUE][i]) ent_d[i].valid = 1'b0;
      end
      if (disp_fire) ent_d[disp_slot] = new_ent;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      end
   end

   always_comb begin
      num_gnt = '0;
      for (int p = 0; p < NUM_ISSUE; p++) num_gnt = num_gnt + CNT_W'(gnt_v[p]);
      count_d = flush ? '0 : count_q + CNT_W'(disp_fire) - num_gnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid <= '0;
         iss_op    <= '0;
         iss_prd   <= '0;
         iss_prd_v <= '0;
         iss_prs1  <= '0;
         iss_prs2  <= '0;
      end else begin
         for (int p = 0; p < NUM_ISSUE; p++) begin
            iss_valid[p] <= gnt_v[p];
            if (gnt_v[p]) begin
               iss_op[p*OPCODE_WIDTH +: OPCODE_WIDTH] <= ent_q[gnt_idx[p]].op;
               iss_prd[p*PRF_WIDTH +: PRF_WIDTH]      <= ent_q[gnt_idx[p]].prd;
               iss_prd_v[p]                           <= ent_q[gnt_idx[p]].prd_v;
               iss_prs1[p*PRF_WIDTH +: PRF_WIDTH]     <= ent_q[gnt_idx[p]].prs1;
               iss_prs2[p*PRF_WIDTH +: PRF_WIDTH]     <= ent_q[gnt_idx[p]].prs2;
            end
         end
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Scenario bench for issue_queue: expected issues are queued at dispatch and matched to monitored ones.
module tb_issue_queue;
   import issue_pkg::*;

   typedef struct packed {
      int         cyc;
      logic [1:0] port;
      logic [6:0] op;
      logic [5:0] prd;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, disp_valid, disp_ready;
   logic [6:0]  disp_op;
   logic [1:0]  disp_fu;
   logic [5:0]  disp_prd, disp_prs1, disp_prs2;
   logic        disp_prd_v, disp_prs1_v, disp_prs1_rdy, disp_prs2_v, disp_prs2_rdy;
   logic [1:0]  wb_valid;
   logic [11:0] wb_prd;
   logic [3:0]  iss_ready, iss_valid, iss_prd_v;
   logic [27:0] iss_op;
   logic [23:0] iss_prd, iss_prs1, iss_prs2;
   logic [4:0]  count;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   rec_t exp_q[$];
   rec_t obs_q[$];

   issue_queue u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .disp_valid    (disp_valid),
      .disp_ready    (disp_ready),
      .disp_op       (disp_op),
      .disp_fu       (disp_fu),
      .disp_prd      (disp_prd),
      .disp_prd_v    (disp_prd_v),
      .disp_prs1     (disp_prs1),
      .disp_prs1_v   (disp_prs1_v),
      .disp_prs1_rdy (disp_prs1_rdy),
      .disp_prs2     (disp_prs2),
      .disp_prs2_v   (disp_prs2_v),
      .disp_prs2_rdy (disp_prs2_rdy),
      .wb_valid      (wb_valid),
      .wb_prd        (wb_prd),
      .iss_ready     (iss_ready),
      .iss_valid     (iss_valid),
      .iss_op        (iss_op),
      .iss_prd       (iss_prd),
      .iss_prd_v     (iss_prd_v),
      .iss_prs1      (iss_prs1),
      .iss_prs2      (iss_prs2),
      .count         (count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      rec_t r;
      for (int p = 0; p < 4; p++) begin
         if (iss_valid[p]) begin
            r.cyc  = cyc;
            r.port = 2'(p);
            r.op   = iss_op[p*7 +: 7];
            r.prd  = iss_prd[p*6 +: 6];
            obs_q.push_back(r);
         end
      end
   end

   task automatic set_idle();
      flush = 0; disp_valid = 0; disp_op = 0; disp_fu = 0; disp_prd = 0; disp_prd_v = 0;
      disp_prs1 = 0; disp_prs1_v = 0; disp_prs1_rdy = 0;
      disp_prs2 = 0; disp_prs2_v = 0; disp_prs2_rdy = 0;
      wb_valid = 0; wb_prd = 0; iss_ready = 4'hF;
   endtask

   task automatic drive_disp(input logic [6:0] op, input logic [1:0] fu, input logic [5:0] prd,
                             input logic [5:0] s1, input logic s1_v, input logic [5:0] s2,
                             input logic s2_v);
      disp_valid = 1; disp_op = op; disp_fu = fu; disp_prd = prd; disp_prd_v = 1;
      disp_prs1 = s1; disp_prs1_v = s1_v; disp_prs1_rdy = 0;
      disp_prs2 = s2; disp_prs2_v = s2_v; disp_prs2_rdy = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      set_idle();
      disp_valid = 1;
      repeat (2) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", disp_ready); end
      total++; if (iss_valid !== 4'h0) begin bad++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
      total++;
      if ({iss_op, iss_prd, iss_prd_v, iss_prs1, iss_prs2} !== '0) begin
         bad++; $display("FAIL reset_payload: got op=%h prd=%h want 0", iss_op, iss_prd);
      end
      disp_valid = 0;
      rst_n = 1;
      @(negedge clk);
      total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", disp_ready); end
   endtask

   task automatic test_fill();
      rec_t e, o;
      int c0;
      for (int i = 0; i < 16; i++) begin
         drive_disp(7'(10 + i), FU_ALU, 6'(i), 6'(20 + i), 1'b1, 6'd0, 1'b0);
         @(negedge clk);
      end
      drive_disp(7'd99, FU_ALU, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
      #1;
      total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", disp_ready); end
      total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count: got %0d want 16", count); end
      @(negedge clk);
      total++; if (count !== 5'd16) begin bad++; $display("FAIL full_hold: got %0d want 16", count); end
      disp_valid = 0;
      wb_valid = 2'b01;
      wb_prd = {6'd0, 6'd23};
      c0 = cyc;
      e.cyc = c0 + 2; e.port = 0; e.op = 7'd13; e.prd = 6'd3;
      exp_q.push_back(e);
      @(negedge clk);
      wb_valid = 0;
      @(negedge clk);
      total++; if (count !== 5'd15) begin bad++; $display("FAIL fill_drain_count: got %0d want 15", count); end
      total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL fill_drain_ready: got %b want 1", disp_ready); end
      flush = 1;
      @(negedge clk);
      flush = 0;
      repeat (2) @(negedge clk);
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         total++;
         if (exp_q.size() == 0) begin
            o = obs_q.pop_front(); bad++;
            $display("FAIL fill_issue: unexpected cyc=%0d port=%0d op=%0d", o.cyc, o.port, o.op);
         end else if (obs_q.size() == 0) begin
            e = exp_q.pop_front(); bad++;
            $display("FAIL fill_issue: missing cyc=%0d port=%0d op=%0d", e.cyc, e.port, e.op);
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL fill_issue: got cyc=%0d port=%0d op=%0d prd=%0d want cyc=%0d port=%0d op=%0d prd=%0d",
                        o.cyc, o.port, o.op, o.prd, e.cyc, e.port, e.op, e.prd);
            end
         end
      end
   endtask

   task automatic test_oldest();
      rec_t e, o;
      int c;
      iss_ready = 4'b1100;
      c = cyc;
      drive_disp(7'd30, FU_ALU, 6'd1, 6'd0, 1'b0, 6'd0, 1'b0); @(negedge clk);
      drive_disp(7'd31, FU_ALU, 6'd2, 6'd0, 1'b0, 6'd0, 1'b0); @(negedge clk);
      drive_disp(7'd32, FU_ALU, 6'd3, 6'd0, 1'b0, 6'd0, 1'b0); @(negedge clk);
      disp_valid = 0;
      iss_ready = 4'hF;
      e.cyc = c + 4; e.port = 0; e.op = 7'd30; e.prd = 6'd1; exp_q.push_back(e);
      e.cyc = c + 4; e.port = 1; e.op = 7'd31; e.prd = 6'd2; exp_q.push_back(e);
      e.cyc = c + 5; e.port = 0; e.op = 7'd32; e.prd = 6'd3; exp_q.push_back(e);
      repeat (4) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL oldest_count: got %0d want 0", count); end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         total++;
         if (exp_q.size() == 0) begin
            o = obs_q.pop_front(); bad++;
            $display("FAIL oldest_issue: unexpected cyc=%0d port=%0d op=%0d", o.cyc, o.port, o.op);
         end else if (obs_q.size() == 0) begin
            e = exp_q.pop_front(); bad++;
            $display("FAIL oldest_issue: missing cyc=%0d port=%0d op=%0d", e.cyc, e.port, e.op);
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL oldest_issue: got cyc=%0d port=%0d op=%0d prd=%0d want cyc=%0d port=%0d op=%0d prd=%0d",
                        o.cyc, o.port, o.op, o.prd, e.cyc, e.port, e.op, e.prd);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      rec_t e, o;
      int c;
      c = cyc;
      drive_disp(7'd40, FU_ALU, 6'd5, 6'd0, 1'b0, 6'd0, 1'b0); @(negedge clk);
      drive_disp(7'd41, FU_ALU, 6'd6, 6'd5, 1'b1, 6'd0, 1'b0); @(negedge clk);
      disp_valid = 0;
      e.cyc = c + 2; e.port = 0; e.op = 7'd40; e.prd = 6'd5; exp_q.push_back(e);
`ifdef IQ_SPEC_WAKEUP_EN
      e.cyc = c + 3; e.port = 0; e.op = 7'd41; e.prd = 6'd6; exp_q.push_back(e);
      repeat (4) @(negedge clk);
`else
      repeat (3) @(negedge clk);
      wb_valid = 2'b10;
      wb_prd = {6'd5, 6'd0};
      e.cyc = cyc + 2; e.port = 0; e.op = 7'd41; e.prd = 6'd6; exp_q.push_back(e);
      @(negedge clk);
      wb_valid = 0;
      repeat (3) @(negedge clk);
`endif
      total++; if (count !== 5'd0) begin bad++; $display("FAIL b2b_count: got %0d want 0", count); end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         total++;
         if (exp_q.size() == 0) begin
            o = obs_q.pop_front(); bad++;
            $display("FAIL b2b_issue: unexpected cyc=%0d port=%0d op=%0d", o.cyc, o.port, o.op);
         end else if (obs_q.size() == 0) begin
            e = exp_q.pop_front(); bad++;
            $display("FAIL b2b_issue: missing cyc=%0d port=%0d op=%0d", e.cyc, e.port, e.op);
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL b2b_issue: got cyc=%0d port=%0d op=%0d prd=%0d want cyc=%0d port=%0d op=%0d prd=%0d",
                        o.cyc, o.port, o.op, o.prd, e.cyc, e.port, e.op, e.prd);
            end
         end
      end
   endtask

   task automatic test_bypass();
      rec_t e, o;
      int c;
      c = cyc;
      drive_disp(7'd50, FU_ALU, 6'd7, 6'd0, 1'b0, 6'd9, 1'b1);
      wb_valid = 2'b01;
      wb_prd = {6'd0, 6'd9};
      e.cyc = c + 2; e.port = 0; e.op = 7'd50; e.prd = 6'd7; exp_q.push_back(e);
      @(negedge clk);
      wb_valid = 0;
      drive_disp(7'd51, FU_ALU, 6'd8, 6'd0, 1'b0, 6'd10, 1'b1);
      @(negedge clk);
      disp_valid = 0;
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd1) begin bad++; $display("FAIL bypass_count: got %0d want 1", count); end
      flush = 1;
      @(negedge clk);
      flush = 0;
      @(negedge clk);
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         total++;
         if (exp_q.size() == 0) begin
            o = obs_q.pop_front(); bad++;
            $display("FAIL bypass_issue: unexpected cyc=%0d port=%0d op=%0d", o.cyc, o.port, o.op);
         end else if (obs_q.size() == 0) begin
            e = exp_q.pop_front(); bad++;
            $display("FAIL bypass_issue: missing cyc=%0d port=%0d op=%0d", e.cyc, e.port, e.op);
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL bypass_issue: got cyc=%0d port=%0d op=%0d prd=%0d want cyc=%0d port=%0d op=%0d prd=%0d",
                        o.cyc, o.port, o.op, o.prd, e.cyc, e.port, e.op, e.prd);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      rec_t e, o;
      int c;
      iss_ready = 4'b1011;
      c = cyc;
      drive_disp(7'd60, FU_MUL, 6'd8, 6'd0, 1'b0, 6'd0, 1'b0);
      @(negedge clk);
      disp_valid = 0;
      repeat (2) @(negedge clk);
      total++; if (count !== 5'd1) begin bad++; $display("FAIL stall_count: got %0d want 1", count); end
      @(negedge clk);
      iss_ready = 4'hF;
      e.cyc = c + 5; e.port = 2; e.op = 7'd60; e.prd = 6'd8; exp_q.push_back(e);
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL stall_release_count: got %0d want 0", count); end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         total++;
         if (exp_q.size() == 0) begin
            o = obs_q.pop_front(); bad++;
            $display("FAIL stall_issue: unexpected cyc=%0d port=%0d op=%0d", o.cyc, o.port, o.op);
         end else if (obs_q.size() == 0) begin
            e = exp_q.pop_front(); bad++;
            $display("FAIL stall_issue: missing cyc=%0d port=%0d op=%0d", e.cyc, e.port, e.op);
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL stall_issue: got cyc=%0d port=%0d op=%0d prd=%0d want cyc=%0d port=%0d op=%0d prd=%0d",
                        o.cyc, o.port, o.op, o.prd, e.cyc, e.port, e.op, e.prd);
            end
         end
      end
   endtask

   task automatic test_flush();
      rec_t o;
      for (int i = 0; i < 6; i++) begin
         drive_disp(7'(70 + i), FU_ALU, 6'(i), 6'd50, 1'b1, 6'd0, 1'b0);
         @(negedge clk);
      end
      drive_disp(7'd76, FU_ALU, 6'd12, 6'd0, 1'b0, 6'd0, 1'b0);
      @(negedge clk);
      total++; if (count !== 5'd7) begin bad++; $display("FAIL flush_pre_count: got %0d want 7", count); end
      flush = 1;
      drive_disp(7'd77, FU_ALU, 6'd13, 6'd0, 1'b0, 6'd0, 1'b0);
      #1;
      total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", disp_ready); end
      @(negedge clk);
      flush = 0;
      disp_valid = 0;
      total++; if (count !== 5'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
      total++; if (iss_valid !== 4'h0) begin bad++; $display("FAIL flush_iss_valid: got %b want 0", iss_valid); end
      wb_valid = 2'b01;
      wb_prd = {6'd0, 6'd50};
      @(negedge clk);
      wb_valid = 0;
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL flush_after_count: got %0d want 0", count); end
      while (obs_q.size() > 0) begin
         total++; bad++;
         o = obs_q.pop_front();
         $display("FAIL flush_issue: unexpected cyc=%0d port=%0d op=%0d", o.cyc, o.port, o.op);
      end
   endtask

   task automatic test_reset_mid();
      rec_t o;
      for (int i = 0; i < 3; i++) begin
         drive_disp(7'(80 + i), FU_ALU, 6'(i), 6'd55, 1'b1, 6'd0, 1'b0);
         @(negedge clk);
      end
      disp_valid = 0;
      #2 rst_n = 0;
      #1;
      total++; if (count !== 5'd0) begin bad++; $display("FAIL midreset_count: got %0d want 0", count); end
      total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready: got %b want 0", disp_ready); end
      @(negedge clk);
      rst_n = 1;
      wb_valid = 2'b01;
      wb_prd = {6'd0, 6'd55};
      @(negedge clk);
      wb_valid = 0;
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL midreset_after_count: got %0d want 0", count); end
      while (obs_q.size() > 0) begin
         total++; bad++;
         o = obs_q.pop_front();
         $display("FAIL midreset_issue: unexpected cyc=%0d port=%0d op=%0d", o.cyc, o.port, o.op);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_oldest();
      test_back_to_back();
      test_bypass();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
